// File: rtl/hdl_ram_pipe_if.sv
// Port bundle for hdl_ram_pipe: write port A, read port B and the read-side status outputs.
// The master side drives the write and read requests; the RAM is the slave.
interface hdl_ram_pipe_if #(
  parameter int WIDTH  = 272,
  parameter int ADDR_W = 8
);
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WIDTH-1:0]  dina;
  logic              renb;
  logic [ADDR_W-1:0] addrb;
  logic [WIDTH-1:0]  doutb;
  logic              doutb_valid;
  logic              addr_err;

  modport master (
    output wea, addra, dina, renb, addrb,
    input  doutb, doutb_valid, addr_err
  );

  modport slave (
    input  wea, addra, dina, renb, addrb,
    output doutb, doutb_valid, addr_err
  );
endinterface

// File: rtl/hdl_ram_pipe.sv
// Simple dual-port RAM with an RD_LAT-deep read pipeline for QPMM/postadder operands.
// Define HDL_RAM_PIPE_FWD_EN for write-first forwarding; otherwise reads are read-first.
module hdl_ram_pipe #(
  parameter int WIDTH  = 272,
  parameter int DEPTH  = 141,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  hdl_ram_pipe_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem      [DEPTH];
  logic [WIDTH-1:0]  data_q   [RD_LAT];
  logic [WIDTH-1:0]  data_d   [RD_LAT];
  logic [WIDTH-1:0]  fwd_data [RD_LAT];
  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  doutb_q, doutb_d;
  logic              doutb_valid_q, doutb_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              addra_in, addrb_in;
  logic              wr_ok, rd_ok;
  logic [WIDTH-1:0]  rd_word;
`ifdef HDL_RAM_PIPE_FWD_EN
  logic [ADDR_W-1:0] tag_q [RD_LAT];
  logic [ADDR_W-1:0] tag_d [RD_LAT];
`endif

  assign addra_in = ({1'b0, bus.addra} < DEPTH_C);
  assign addrb_in = ({1'b0, bus.addrb} < DEPTH_C);
  assign wr_ok    = bus.wea && addra_in;
  assign rd_ok    = bus.renb && addrb_in;

  // Array has no reset so it maps onto block RAM and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[bus.addra] <= bus.dina;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[bus.addrb];
    end
`ifdef HDL_RAM_PIPE_FWD_EN
    if (rd_ok && wr_ok && (bus.addra == bus.addrb)) begin
      rd_word = bus.dina;
    end
`endif
  end

  // Each in-flight stage is patched by a same-address write before it shifts on.
  always_comb begin
    valid_d = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      fwd_data[k] = data_q[k];
`ifdef HDL_RAM_PIPE_FWD_EN
      if (wr_ok && valid_q[k] && (tag_q[k] == bus.addra)) begin
        fwd_data[k] = bus.dina;
      end
`endif
    end
    data_d[0]  = rd_word;
    valid_d[0] = bus.renb;
`ifdef HDL_RAM_PIPE_FWD_EN
    tag_d[0]   = bus.addrb;
`endif
    for (int k = 1; k < RD_LAT; k++) begin
      data_d[k]  = fwd_data[k-1];
      valid_d[k] = valid_q[k-1];
`ifdef HDL_RAM_PIPE_FWD_EN
      tag_d[k]   = tag_q[k-1];
`endif
    end
    doutb_d       = valid_q[RD_LAT-1] ? fwd_data[RD_LAT-1] : doutb_q;
    doutb_valid_d = valid_q[RD_LAT-1];
    addr_err_d    = addr_err_q | (bus.wea & ~addra_in) | (bus.renb & ~addrb_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        data_q[k] <= '0;
`ifdef HDL_RAM_PIPE_FWD_EN
        tag_q[k]  <= '0;
`endif
      end
      valid_q       <= '0;
      doutb_q       <= '0;
      doutb_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      for (int k = 0; k < RD_LAT; k++) begin
        data_q[k] <= data_d[k];
`ifdef HDL_RAM_PIPE_FWD_EN
        tag_q[k]  <= tag_d[k];
`endif
      end
      valid_q       <= valid_d;
      doutb_q       <= doutb_d;
      doutb_valid_q <= doutb_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign bus.doutb       = doutb_q;
  assign bus.doutb_valid = doutb_valid_q;
  assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_hdl_ram_pipe.sv
// Testbench for hdl_ram_pipe: three instances (RD_LAT 3, 1, 8) share one stimulus stream,
// each checked against its own scoreboard queue and a bench-side memory model.
`timescale 1ns/1ps
module tb_hdl_ram_pipe;
  localparam int WIDTH  = 272;
  localparam int DEPTH  = 141;
  localparam int ADDR_W = 8;
  localparam int NDUT   = 3;
  localparam int LAT0   = 3;
  localparam int LAT1   = 1;
  localparam int LAT2   = 8;
  localparam int NVEC   = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    word_t data;
    int    addr;
    int    issue;
  } sbEntry_t;
  typedef struct {
    logic  we;
    int    wa;
    word_t wd;
    logic  re;
    int    ra;
    word_t expRd;
  } vector_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdl_ram_pipe_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus (), busL1 (), busL8 ();

  assign busL1.wea   = bus.wea;
  assign busL1.addra = bus.addra;
  assign busL1.dina  = bus.dina;
  assign busL1.renb  = bus.renb;
  assign busL1.addrb = bus.addrb;
  assign busL8.wea   = bus.wea;
  assign busL8.addra = bus.addra;
  assign busL8.dina  = bus.dina;
  assign busL8.renb  = bus.renb;
  assign busL8.addrb = bus.addrb;

  hdl_ram_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(LAT0))
    u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  hdl_ram_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(LAT1))
    u_lat1 (.clk(clk), .rst(rst), .bus(busL1.slave));
  hdl_ram_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(LAT2))
    u_lat8 (.clk(clk), .rst(rst), .bus(busL8.slave));

  word_t doutA  [NDUT];
  logic  validA [NDUT];
  logic  errA   [NDUT];
  assign doutA[0]  = bus.doutb;
  assign doutA[1]  = busL1.doutb;
  assign doutA[2]  = busL8.doutb;
  assign validA[0] = bus.doutb_valid;
  assign validA[1] = busL1.doutb_valid;
  assign validA[2] = busL8.doutb_valid;
  assign errA[0]   = bus.addr_err;
  assign errA[1]   = busL1.addr_err;
  assign errA[2]   = busL8.addr_err;

  sbEntry_t sbQ [NDUT][$];
  word_t    model [DEPTH];
  word_t    expDout [NDUT];
  logic     errExp;
  int       edgeNo;
  int       checks;
  int       errors;
  vector_t  vec [NVEC];

  function automatic int latOf(input int d);
    case (d)
      0:       return LAT0;
      1:       return LAT1;
      default: return LAT2;
    endcase
  endfunction

  function automatic word_t modelRead(input int a);
    return (a < DEPTH) ? model[a] : '0;
  endfunction

  function automatic vector_t mkVec(input logic we, input int wa, input word_t wd,
                                    input logic re, input int ra, input word_t expRd);
    vector_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.expRd = expRd;
    return v;
  endfunction

  task automatic compareVal(input string name, input int d, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d edge %0d: got %h, expected %h", name, d, edgeNo, act, exp);
    end
  endtask

  // Each DUT owes a beat exactly when the oldest queued read reaches its latency.
  task automatic checkOutput();
    logic     expValid;
    sbEntry_t e;
    for (int d = 0; d < NDUT; d++) begin
      expValid = (sbQ[d].size() > 0) && (sbQ[d][0].issue + latOf(d) == edgeNo);
      compareVal("doutb_valid", d, word_t'(validA[d]), word_t'(expValid));
      if (expValid) begin
        e = sbQ[d].pop_front();
        expDout[d] = e.data;
      end
      compareVal("doutb", d, doutA[d], expDout[d]);
      compareVal("addr_err", d, word_t'(errA[d]), word_t'(errExp));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic we, input int wa, input word_t wd,
                               input logic re, input int ra, input word_t expRd);
    sbEntry_t e;
    rst       = r;
    bus.wea   = we;
    bus.addra = ADDR_W'(wa);
    bus.dina  = wd;
    bus.renb  = re;
    bus.addrb = ADDR_W'(ra);
    if (!r) begin
      if (re) begin
        for (int d = 0; d < NDUT; d++) begin
          e.data  = expRd;
          e.addr  = ra;
          e.issue = edgeNo + 1;
          sbQ[d].push_back(e);
        end
      end
      if (we && (wa < DEPTH)) begin
`ifdef HDL_RAM_PIPE_FWD_EN
        for (int d = 0; d < NDUT; d++) begin
          for (int i = 0; i < sbQ[d].size(); i++) begin
            if (sbQ[d][i].addr == wa) sbQ[d][i].data = wd;
          end
        end
`endif
        model[wa] = wd;
      end
      if ((we && (wa >= DEPTH)) || (re && (ra >= DEPTH))) errExp = 1'b1;
    end
    @(posedge clk);
    edgeNo++;
    if (r) begin
      for (int d = 0; d < NDUT; d++) begin
        sbQ[d].delete();
        expDout[d] = '0;
      end
      errExp = 1'b0;
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 0, '0);
  endtask

  initial begin
    rst = 1'b1;
    bus.wea = 1'b0; bus.addra = '0; bus.dina = '0; bus.renb = 1'b0; bus.addrb = '0;
    edgeNo = 0; checks = 0; errors = 0; errExp = 1'b0;
    for (int d = 0; d < NDUT; d++) expDout[d] = '0;

    vec[0]  = mkVec(1'b1, 0,   word_t'(32'h1),   1'b0, 0,   '0);
    vec[1]  = mkVec(1'b1, 1,   word_t'(32'h2),   1'b0, 0,   '0);
    vec[2]  = mkVec(1'b1, 2,   word_t'(32'h3),   1'b0, 0,   '0);
    vec[3]  = mkVec(1'b1, 3,   word_t'(32'h4),   1'b0, 0,   '0);
    vec[4]  = mkVec(1'b1, 4,   word_t'(32'h5),   1'b0, 0,   '0);
    vec[5]  = mkVec(1'b1, 140, word_t'(32'hABC), 1'b0, 0,   '0);
    vec[6]  = mkVec(1'b1, 9,   word_t'(32'h11),  1'b0, 0,   '0);
    vec[7]  = mkVec(1'b0, 0,   '0,               1'b1, 0,   word_t'(32'h1));
    vec[8]  = mkVec(1'b0, 0,   '0,               1'b1, 1,   word_t'(32'h2));
    vec[9]  = mkVec(1'b0, 0,   '0,               1'b1, 2,   word_t'(32'h3));
    vec[10] = mkVec(1'b0, 0,   '0,               1'b1, 3,   word_t'(32'h4));
    vec[11] = mkVec(1'b0, 0,   '0,               1'b1, 4,   word_t'(32'h5));
    vec[12] = mkVec(1'b1, 5,   word_t'(32'h66),  1'b1, 2,   word_t'(32'h3));
    vec[13] = mkVec(1'b0, 0,   '0,               1'b1, 5,   word_t'(32'h66));
    vec[14] = mkVec(1'b0, 0,   '0,               1'b0, 0,   '0);
    vec[15] = mkVec(1'b0, 0,   '0,               1'b1, 140, word_t'(32'hABC));

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, '0);
    applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, '0);

    $display("[TB] table vectors");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b0, vec[i].we, vec[i].wa, vec[i].wd, vec[i].re, vec[i].ra, vec[i].expRd);
    end
    idle(10);

    $display("[TB] same-edge collision on addr 9");
    applyStimulus(1'b0, 1'b1, 9, word_t'(32'h77), 1'b1, 9, modelRead(9));
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 9, modelRead(9));
    idle(10);

    $display("[TB] write behind an in-flight read of addr 3");
    applyStimulus(1'b0, 1'b1, 3, word_t'(32'h5), 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 3, modelRead(3));
    applyStimulus(1'b0, 1'b1, 3, word_t'(32'h9), 1'b0, 0, '0);
    idle(10);

    $display("[TB] out-of-range accesses");
    applyStimulus(1'b0, 1'b1, 13, word_t'(32'h13), 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b1, 141, word_t'(32'hDEAD), 1'b1, 200, '0);
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 13, modelRead(13));
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 140, modelRead(140));
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 0, modelRead(0));
    idle(10);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 0, modelRead(0));
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1, modelRead(1));
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 2, modelRead(2));
    applyStimulus(1'b1, 1'b1, 0, word_t'(32'hBAD), 1'b1, 0, '0);
    applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, '0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 0, modelRead(0));
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 1, modelRead(1));
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 2, modelRead(2));
    idle(10);

    for (int d = 0; d < NDUT; d++) begin
      compareVal("drain", d, word_t'(sbQ[d].size()), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
